alu_mul_seq: RTL

//  Multi-cycle unsigned W x W -> 2W multiply sequencer that borrows the shared single-cycle ALU
//  (add/sub/logic/shift, aopcode[2:0], csr_t flags).

---
 rtl/alu_mul_seq_pkg.sv | 29 ++
 rtl/alu_mul_seq_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared types for the multiply sequencer and the single-cycle ALU it borrows:
// ALU flag word, ALU opcodes and the sequencer state encoding.
package alu_mul_seq_pkg;

  typedef struct packed {
    logic Negative;
    logic Zero;
    logic Carry;
    logic Overflow;
  } csr_t;

  typedef enum logic [2:0] {
    AOP_ADD = 3'b000,
    AOP_SUB,
    AOP_AND,
    AOP_OR,
    AOP_XOR,
    AOP_NOT,
    AOP_SHR,
    AOP_SHL
  } aop_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mseq_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response handshake between the execute stage (master) and the
// multiply sequencer (slave).
interface alu_mul_seq_if #(
  parameter int W = 16
) ();

  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_prod;
  logic           rsp_zero;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod, rsp_zero
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned W x W -> 2W shift-add multiplier that borrows the shared ALU for
// W add steps and stalls the core while it owns it.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_mul_seq_if.slave       bus,
  input  logic [W-1:0]       core_src1,
  input  logic [W-1:0]       core_src2,
  input  aop_t               core_aop,
  output logic               core_stall,
  output logic [W-1:0]       alu_src1,
  output logic [W-1:0]       alu_src2,
  output aop_t               alu_aop,
  input  logic [W-1:0]       alu_result,
  input  csr_t               alu_csr
);

  mseq_state_t      state_q;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;
  logic [W-1:0]     mcand_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            mcand_q <= bus.req_a;
            lo_q    <= bus.req_b;
            hi_q    <= '0;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Partial sum plus carry shifts right into hi; its LSB enters lo,
          // retiring one multiplier bit per step.
          hi_q    <= {alu_csr.Carry, alu_result[W-1:1]};
          lo_q    <= {alu_result[0], lo_q[W-1:1]};
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(W - 1)) state_q <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    alu_src1 = core_src1;
    alu_src2 = core_src2;
    alu_aop  = core_aop;
    if (state_q == RUN) begin
      alu_src1 = hi_q;
      alu_src2 = lo_q[0] ? mcand_q : '0;
      alu_aop  = AOP_ADD;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign core_stall    = (state_q == RUN);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_prod  = (state_q == DONE) ? {hi_q, lo_q} : '0;
  assign bus.rsp_zero  = (state_q == DONE) && ({hi_q, lo_q} == '0);

  // Only Carry participates in the multiply; the other flags are left alone.
  logic unused_csr_flags;
  assign unused_csr_flags = ^{alu_csr.Negative, alu_csr.Zero, alu_csr.Overflow};

endmodule
